// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that drives the select of a downstream N:1 mux.
// One grant at a time, released by done, request withdrawal or hold timeout.
module mux_sel_arbiter #(
  parameter int num_req   = 4,
  parameter int sel_width = 2,
  parameter int max_hold  = 15,
  parameter int cnt_width = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [num_req-1:0]   req,
  input  logic                 done,
  output logic [sel_width-1:0] sel,
  output logic [num_req-1:0]   grant,
  output logic                 valid
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [sel_width-1:0] LAST_IDX  = sel_width'(num_req - 1);
  localparam logic [sel_width:0]   NUM_REQ_W = (sel_width + 1)'(num_req);
  localparam logic [cnt_width-1:0] HCNT_MAX  = '1;
  localparam bit                   HOLD_EN   = (max_hold != 0);
  localparam logic [cnt_width-1:0] HOLD_LAST = HOLD_EN ? cnt_width'(max_hold - 1) : '0;
  localparam logic [num_req-1:0]   ONE_HOT_0 = num_req'(1);

  state_t               r_state;
  logic [sel_width-1:0] r_ptr;
  logic [cnt_width-1:0] r_hcnt;
  logic [sel_width-1:0] r_sel;
  logic [num_req-1:0]   r_grant;
  logic                 r_valid;

  state_t               w_state_nxt;
  logic [sel_width-1:0] w_ptr_nxt;
  logic [cnt_width-1:0] w_hcnt_nxt;
  logic [sel_width-1:0] w_sel_nxt;
  logic [num_req-1:0]   w_grant_nxt;
  logic                 w_valid_nxt;

  logic [2*num_req-1:0] w_req_dbl;
  logic [num_req-1:0]   w_req_rot;
  logic                 w_found;
  logic [sel_width-1:0] w_offset;
  logic [sel_width:0]   w_sum;
  logic [sel_width-1:0] w_winner;
  logic                 w_hold_expired;
  logic                 w_release;
  logic [sel_width-1:0] w_sel_succ;

  // Rotate requests so bit 0 is the source at ptr; the first set bit is then
  // the winner's distance from ptr.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_req_dbl = {req, req} >> r_ptr;
    w_req_rot = w_req_dbl[num_req-1:0];
    w_found   = 1'b0;
    w_offset  = '0;
    for (int i = 0; i < num_req; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found  = 1'b1;
        w_offset = sel_width'(i);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_offset};
    if (w_sum >= NUM_REQ_W) begin
      w_sum = w_sum - NUM_REQ_W;
    end
    w_winner = w_sum[sel_width-1:0];
  end

  assign w_hold_expired = HOLD_EN && (r_hcnt == HOLD_LAST);
  assign w_release      = done || !req[r_sel] || w_hold_expired;
  assign w_sel_succ     = (r_sel == LAST_IDX) ? '0 : r_sel + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hcnt_nxt  = r_hcnt;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;

    unique case (r_state)
      ST_IDLE: begin
        // done is ignored here; only a pending request moves the FSM.
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        if (w_found) begin
          w_sel_nxt   = w_winner;
          w_grant_nxt = ONE_HOT_0 << w_winner;
          w_valid_nxt = 1'b1;
          w_hcnt_nxt  = '0;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          // Any mix of release causes yields one release and one ptr step.
          w_grant_nxt = '0;
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = w_sel_succ;
          w_hcnt_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_hcnt != HCNT_MAX) begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, matching the hardware.
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_hcnt  <= '0;
      r_sel   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign sel   = r_sel;
  assign grant = r_grant;
  assign valid = r_valid;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: a transaction-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mux_sel_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int SEL_WIDTH = 2;
  localparam int MAX_HOLD  = 15;
  localparam int CNT_WIDTH = 4;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic                 done;
  logic [SEL_WIDTH-1:0] sel;
  logic [NUM_REQ-1:0]   grant;
  logic                 valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who owns the mux, how long they have held it, and who is next.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_len   = 0;

  mux_sel_arbiter #(
    .num_req  (NUM_REQ),
    .sel_width(SEL_WIDTH),
    .max_hold (MAX_HOLD),
    .cnt_width(CNT_WIDTH)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .done (done),
    .sel  (sel),
    .grant(grant),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_valid_timeout", 32'(valid), 32'd1);
  endtask

  // Model update: one arbitration decision per clock, from the rules alone.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_len   = 0;
    end else if (m_busy) begin
      m_len = m_len + 1;
      if (done || !req[m_owner] || (MAX_HOLD != 0 && m_len >= MAX_HOLD)) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NUM_REQ;
      end
    end else if (req != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!m_busy && req[(m_ptr + k) % NUM_REQ]) begin
          m_busy  = 1'b1;
          m_owner = (m_ptr + k) % NUM_REQ;
          m_len   = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_valid", 32'(valid), 32'(m_busy));
    check("model_grant", 32'(grant), m_busy ? (32'd1 << m_owner) : 32'd0);
    check("model_sel",   32'(sel),   32'(m_owner));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [NUM_REQ-1:0] rot_exp [9];
  int                 hold_len;

  initial begin
    rot_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    req  = '0;
    done = 1'b0;
    rst  = 1'b0;
    #1 rst = 1'b1;

    // Reset state, then first grant one edge after rst falls.
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_sel",   32'(sel),   32'd0);
    req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("first_sel",   32'(sel),   32'd0);
    check("first_grant", 32'(grant), 32'b0001);
    check("first_valid", 32'(valid), 32'd1);

    // Asynchronous reset in mid-grant, then restart from source 0.
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_grant", 32'(grant), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_sel",   32'(sel),   32'd0);
    check("restart_grant", 32'(grant), 32'b0001);

    // Single requester 2 released by done after three valid cycles.
    req = 4'b0100;
    @(negedge clk);
    check("t2_bubble", 32'(valid), 32'd0);
    wait_valid(8);
    check("t2_sel",   32'(sel),   32'd2);
    check("t2_grant", 32'(grant), 32'b0100);
    @(negedge clk);
    check("t2_hold1", 32'(valid), 32'd1);
    @(negedge clk);
    check("t2_hold2", 32'(valid), 32'd1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("t2_released", 32'(valid), 32'd0);
    @(negedge clk);
    check("t2_regrant_valid", 32'(valid), 32'd1);
    check("t2_regrant_sel",   32'(sel),   32'd2);
    req = '0;
    @(negedge clk);
    check("t2_withdrawn", 32'(valid), 32'd0);

    // Full rotation with done held high, one bubble between grants.
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("rot_grant_%0d", i), 32'(grant), 32'(rot_exp[i]));
      check($sformatf("rot_valid_%0d", i), 32'(valid), 32'(rot_exp[i] != '0));
    end
    req  = '0;
    done = 1'b0;
    @(negedge clk);
    check("rot_end_valid", 32'(valid), 32'd0);

    // Hold timeout on source 3: exactly MAX_HOLD valid cycles, then regrant.
    req = 4'b1000;
    wait_valid(8);
    check("to_sel", 32'(sel), 32'd3);
    hold_len = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid) hold_len++;
      else break;
    end
    check("to_hold_len", 32'(hold_len), 32'd15);
    @(negedge clk);
    check("to_regrant_valid", 32'(valid), 32'd1);
    check("to_regrant_sel",   32'(sel),   32'd3);
    req = '0;
    @(negedge clk);
    check("to_end_valid", 32'(valid), 32'd0);

    // Withdrawal release of source 1, then done in IDLE has no effect.
    req = 4'b0010;
    wait_valid(8);
    check("wd_sel",   32'(sel),   32'd1);
    check("wd_grant", 32'(grant), 32'b0010);
    @(negedge clk);
    check("wd_hold", 32'(valid), 32'd1);
    req = '0;
    @(negedge clk);
    check("wd_released", 32'(valid), 32'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("idle_done_valid", 32'(valid), 32'd0);
    check("idle_done_grant", 32'(grant), 32'd0);
    check("idle_done_sel",   32'(sel),   32'd1);
    @(negedge clk);
    check("idle_done_still", 32'(valid), 32'd0);

    // done and timeout together on source 3: one ptr step, so 0 wins next.
    req = 4'b1000;
    wait_valid(8);
    check("both_sel", 32'(sel), 32'd3);
    repeat (14) @(negedge clk);
    check("both_last_cycle", 32'(valid), 32'd1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 4'b1001;
    check("both_released", 32'(valid), 32'd0);
    @(negedge clk);
    check("both_next_sel",   32'(sel),   32'd0);
    check("both_next_grant", 32'(grant), 32'b0001);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 parallel mux and generates its select.
- Collects per-source requests, grants exactly one source at a time, and drives a registered select index (sel) into the mux. It also drives a valid qualifier so downstream logic samples the mux output only while a grant is held.
- Grant is released by a done handshake, request withdrawal, or a hold timeout.

Parameters:
- num_req, 4, number of requesting sources (mux data inputs); must satisfy num_req <= 2**sel_width.
- sel_width, 2, width of the select index driven to the mux.
- max_hold, 15, maximum grant length in cycles; 0 disables the timeout.
- cnt_width, 4, width of the hold counter; must satisfy max_hold <= 2**cnt_width - 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  num_req  per-source request, level-sensitive.
- done  input  1  consumer pulse; releases the current grant.
- sel  output  sel_width  registered select index to the mux.
- grant  output  num_req  registered one-hot grant; all zero when idle.
- valid  output  1  high while a grant is held (mux output meaningful).

Behaviour:
- Interface: single clock clk; reset rst is asynchronous and active-high.
- Reset values, applied immediately on rst=1 regardless of clk:
  - state=IDLE, sel=0, grant=0, valid=0.
  - Round-robin pointer ptr=0, hold counter hcnt=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE state:
  - If req==0: stay in IDLE; outputs hold (sel keeps its last value, grant=0, valid=0).
  - Else: pick winner w, the first index with req[w]=1 scanning ptr, ptr+1, ... num_req-1, 0, ... ptr-1 (wrapping).
  - At that edge: sel<=w, grant<=1<<w, valid<=1, hcnt<=0, state<=GRANT.
  - Latency: req sampled at edge N gives valid=1 after edge N, so one cycle from request to grant.
- GRANT state:
  - sel and grant are stable for the whole grant.
  - hcnt increments by 1 each cycle and saturates at 2**cnt_width-1.
  - Release condition R, evaluated each edge, is any of:
    - done==1
    - req[sel]==0 (requester withdrew)
    - max_hold!=0 and hcnt==max_hold-1
  - On R: grant<=0, valid<=0, ptr<=(sel+1) wrapped at num_req, hcnt<=0, state<=IDLE. sel keeps its value.
  - Without R: stay in GRANT.
  - A grant lasts at most max_hold cycles of valid=1.
- Gap rule: every release is followed by exactly one IDLE cycle with valid=0, even if requests are pending. Back-to-back grants are therefore separated by one bubble.
- Simultaneous events:
  - Several release causes in the same cycle produce a single release with a single ptr advance.
  - done asserted while in IDLE is ignored.
  - New requests arriving during GRANT are not considered until the next IDLE cycle.
- Fairness: after source k is served, k has the lowest priority for the next arbitration. With all sources requesting, grants rotate 0,1,2,3,0,...
- Wrap-around: ptr and sel wrap from num_req-1 to 0; sel never exceeds num_req-1.
- Reset mid-grant: valid and grant drop immediately (asynchronously). After rst deasserts, arbitration restarts from ptr=0.
- max_hold=1: each grant lasts exactly one valid cycle, then the bubble.

Test Plan:
- Reset with req=4'b1111 held, rst deasserted at cycle 2 → sel=0, grant=0001, valid=1 after the first edge post-reset. Asserting rst mid-grant drops valid to 0 immediately.
- req=4'b0100, done pulsed 3 cycles after valid rises → sel=2, grant=0100, valid high for exactly 3 cycles, then one valid=0 cycle, then re-grant of 2 (ptr=3, wraps to 2).
- req=4'b1111, done pulsed every valid cycle → grant sequence 0001,0010,0100,1000,0001, with exactly one valid=0 bubble between each.
- req=4'b1000, done never asserted, max_hold=15 → valid high for exactly 15 cycles, released by timeout, ptr=0, next grant is sel=3 again.
- req[1]=1 granted, then req=4'b0000 after 2 cycles → release on withdrawal, valid=0. done pulse while in IDLE → no state change.
- Release with done=1 and timeout in the same cycle, granted source 3 → single release, ptr=0; next grant with req=4'b1001 goes to sel=0.
